// File: rtl/snoopy_bus_arbiter_if.sv
// Bus-side signals shared between the snoopy bus arbiter and its cache controllers.
// Handshake: a device holds request[i] high until grant[i] rises, and keeps it high for as
// long as it wants the bus; dropping request[i] while granted releases ownership.
interface snoopy_bus_arbiter_if #(
  parameter int NUM_DEVICES = 4,
  parameter int ID_WIDTH    = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
);
  logic [NUM_DEVICES-1:0] request;
  logic [NUM_DEVICES-1:0] grant;
  logic [ID_WIDTH-1:0]    grantId;
  logic                   busBusy;
  logic                   preempted;

  modport master (
    input  request,
    output grant,
    output grantId,
    output busBusy,
    output preempted
  );

  modport slave (
    output request,
    input  grant,
    input  grantId,
    input  busBusy,
    input  preempted
  );
endinterface

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner arbiter for the shared snoopy bus, with a one-cycle turnaround after release.
// Define SNOOPY_BUS_ARBITER_TIMEOUT_EN to build the hold-timeout preemption.
module snoopy_bus_arbiter #(
  parameter int NUM_DEVICES     = 4,
  parameter int ID_WIDTH        = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  snoopy_bus_arbiter_if.master bus,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int SW = ID_WIDTH + 1;

  state_t                 state, state_next;
  logic [ID_WIDTH-1:0]    pointer, pointer_next;
  logic [ID_WIDTH-1:0]    owner, owner_next;
  logic [NUM_DEVICES-1:0] grant_q, grant_next;
  logic                   busy_q, busy_next;
  logic                   pre_q, pre_next;

  logic [ID_WIDTH-1:0]    winner;
  logic                   winner_found;
  logic [SW-1:0]          scan_sum;
  logic [ID_WIDTH-1:0]    owner_inc;
  logic                   timeout_fire;

  // Scan upward from the pointer with wrap; the first requester found wins.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    scan_sum     = '0;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      scan_sum = {1'b0, pointer} + SW'(k);
      if (scan_sum >= SW'(NUM_DEVICES)) begin
        scan_sum = scan_sum - SW'(NUM_DEVICES);
      end
      if (!winner_found && bus.request[scan_sum[ID_WIDTH-1:0]]) begin
        winner       = scan_sum[ID_WIDTH-1:0];
        winner_found = 1'b1;
      end
    end
  end

  assign owner_inc = (owner == ID_WIDTH'(NUM_DEVICES - 1)) ? '0 : owner + 1'b1;

`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              others_req;

  // hold_cnt counts completed owned cycles, so the limit is reached during owned cycle MAX.
  assign others_req   = |(bus.request & ~grant_q);
  assign timeout_fire = (state == GRANT) && others_req &&
                        (hold_cnt >= HOLD_W'(MAX_HOLD_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_W'(MAX_HOLD_CYCLES)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    pointer_next = pointer;
    owner_next   = owner;
    grant_next   = grant_q;
    pre_next     = 1'b0;
    case (state)
      IDLE: begin
        if (winner_found) begin
          state_next = GRANT;
          owner_next = winner;
          grant_next = NUM_DEVICES'(1) << winner;
        end
      end
      GRANT: begin
        if (!bus.request[owner] || timeout_fire) begin
          state_next   = RELEASE;
          grant_next   = '0;
          pointer_next = owner_inc;
          pre_next     = timeout_fire;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pointer <= '0;
      owner   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state   <= state_next;
      pointer <= pointer_next;
      owner   <= owner_next;
      grant_q <= grant_next;
      busy_q  <= busy_next;
      pre_q   <= pre_next;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grantId   = owner;
  assign bus.busBusy   = busy_q;
  assign bus.preempted = pre_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Self-checking bench for snoopy_bus_arbiter: directed vector table, corner sequences,
// and random request traffic against an ownership-level reference model.
module tb_snoopy_bus_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int MAXH = 8;
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoopy_bus_arbiter_if #(.NUM_DEVICES(N), .ID_WIDTH(IDW)) bus ();
  logic [1:0] fsm_state;

  snoopy_bus_arbiter #(
    .NUM_DEVICES    (N),
    .ID_WIDTH       (IDW),
    .MAX_HOLD_CYCLES(MAXH)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .bus      (bus),
    .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  // Owner-centric view: who holds the bus, whether the turnaround is pending,
  // where the rotation starts next, and how long the owner has held it.
  int m_owner;
  bit m_turn;
  int m_ptr;
  int m_id;
  int m_held;
  bit m_pre;

  function automatic void model_reset();
    m_owner = -1;
    m_turn  = 1'b0;
    m_ptr   = 0;
    m_id    = 0;
    m_held  = 0;
    m_pre   = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    bit           found;
    int           idx;
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      m_held = m_held + 1;
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (TIMEOUT && m_held >= MAXH && others != '0)) begin
        m_pre   = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else if (r != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && r[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_id    = idx;
          m_held  = 0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] model_out();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, IDW'(m_id), (m_owner >= 0) || m_turn, m_pre};
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    logic [7:0] e;
    exp_q.push_back(exp);
    got = {bus.grant, bus.grantId, bus.busBusy, bus.preempted};
    e   = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got grant=%b id=%0d busy=%b pre=%b, expected grant=%b id=%0d busy=%b pre=%b",
               name, $time, got[7:4], got[3:2], got[1], got[0], e[7:4], e[3:2], e[1], e[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1, so inputs change and outputs are sampled away from edges.
  task automatic step(input logic [N-1:0] r, input string name);
    bus.request = r;
    model_step(r);
    @(posedge clk);
    #1;
    check(name, model_out());
  endtask

  task automatic do_reset();
    bus.request = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           busy;
  } vec_t;

  vec_t tbl[16];

  int held, gap, ngr, owned, since, rise, pre_hits;
  bit drop_seen, pre_at_drop;
  logic [N-1:0] prev_g, rr;
  int order[$];
  int gaps[$];
  int exp_order[5];

  initial begin
    // single requester, pointer move then 1011, non-owner pulse not latched
    tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[1]  = '{4'b0000, 4'b0000, 2'd2, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[3]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd1, 1'b1};
    tbl[5]  = '{4'b1011, 4'b0000, 2'd1, 1'b0};
    tbl[6]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
    tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 2'd3, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[11] = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    exp_order = '{0, 1, 2, 3, 0};

    bus.request = '0;
    model_reset();
    #2;
    check("reset_state", 8'h00);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      bus.request = tbl[i].req;
      model_step(tbl[i].req);
      @(posedge clk);
      #1;
      check($sformatf("table_row%0d", i), {tbl[i].gnt, tbl[i].id, tbl[i].busy, 1'b0});
    end

    // reset mid-grant: device 2 owns, asynchronous reset, then 0110 picks device 1
    step(4'b0100, "pre_reset_grant");
    step(4'b0100, "pre_reset_hold");
    #3;
    rst_n = 1'b0;
    bus.request = '0;
    #1;
    check("async_reset_clears", 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(4'b0110, "post_reset_model");
    check("post_reset_dev1", {4'b0010, 2'd1, 1'b1, 1'b0});
    step(4'b0100, "post_reset_release");
    step(4'b0000, "post_reset_idle");
    step(4'b0000, "post_reset_idle2");

    // round-robin: everyone requests, each owner releases after 3 owned cycles
    do_reset();
    held = 0; gap = 0; ngr = 0; prev_g = '0;
    for (int c = 0; c < 80 && ngr < 5; c++) begin
      rr = 4'b1111;
      if (bus.grant != '0 && held >= 3) rr = ~bus.grant;
      step(rr, "rr_model");
      if (bus.grant != '0) begin
        if (prev_g == '0) begin
          order.push_back(int'(bus.grantId));
          gaps.push_back(gap);
          ngr++;
          held = 0;
        end
        held++;
        gap = 0;
      end else begin
        gap++;
      end
      prev_g = bus.grant;
    end
    check_int("rr_grant_count", ngr, 5);
    for (int i = 0; i < order.size(); i++) begin
      check_int($sformatf("rr_order%0d", i), order[i], exp_order[i]);
      if (i > 0) check_int($sformatf("rr_gap%0d", i), gaps[i], 2);
    end
    for (int i = 0; i < 3; i++) step(4'b0000, "rr_drain");

`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
    // timeout: device 0 holds, device 1 competes from cycle 2
    do_reset();
    step(4'b0001, "to_grant0");
    owned = 1; drop_seen = 1'b0; pre_at_drop = 1'b0; since = 0; rise = -1;
    for (int c = 0; c < 30; c++) begin
      step(4'b0011, "to_model");
      if (!drop_seen) begin
        if (bus.grant == 4'b0001) owned++;
        else begin
          drop_seen   = 1'b1;
          pre_at_drop = bus.preempted;
        end
      end else begin
        since++;
        if (bus.grant == 4'b0010 && rise < 0) rise = since;
      end
    end
    check_int("to_owned_cycles", owned, MAXH);
    check_int("to_preempt_pulse", int'(pre_at_drop), 1);
    check_int("to_dev1_delay", rise, 2);

    // no competitor: never preempted
    do_reset();
    pre_hits = 0;
    for (int c = 0; c < 100; c++) begin
      step(4'b0001, "solo_model");
      if (bus.preempted) pre_hits++;
    end
    check_int("solo_no_preempt", pre_hits, 0);
    check("solo_still_owner", {4'b0001, 2'd0, 1'b1, 1'b0});
`endif

    // random traffic: each request bit toggles with probability 1/4 per cycle
    do_reset();
    rr = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      end
      step(rr, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
